uart_tx_arbiter: RTL and testbench

// Shares one UART transmit path (byte stream into the uart_with_fifo TX side) between NUM_REQ

---
 rtl/uart_tx_arbiter_pkg.sv | 18 +
 rtl/uart_tx_arbiter_if.sv | 23 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 139 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART TX arbiter: FSM state encoding,
// default header base and a counter-width helper.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } arb_state_e;

    localparam logic [7:0] HDR_BASE_DEFAULT = 8'hA0;

    // Width able to hold values 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bundle between NUM_REQ producers, the arbiter and the UART TX FIFO.
// master = arbiter side, slave = producers plus FIFO side.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 out_valid;
    logic [7:0]           out_data;
    logic                 out_ready;

    modport master (
        input  req_valid, req_data, req_last, out_ready,
        output req_ready, out_valid, out_data
    );

    modport slave (
        output req_valid, req_data, req_last, out_ready,
        input  req_ready, out_valid, out_data
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin search: first asserted valid bit starting at ptr+1,
// wrapping around, so the requester at ptr has the lowest priority.
module uart_tx_arbiter_rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IDW-1:0]     ptr_i,
    output logic               any_valid_o,
    output logic [IDW-1:0]     idx_o
);

    logic [IDW-1:0]     cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] cand_valid;

    // Candidate gi is the requester gi+1 places after the pointer.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        assign cand_idx[gi]   = IDW'((32'(ptr_i) + 32'(gi) + 32'd1) % 32'(NUM_REQ));
        assign cand_valid[gi] = valid_i[cand_idx[gi]];
    end

    always_comb begin
        any_valid_o = |valid_i;
        idx_o       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand_valid[k]) begin
                idx_o = cand_idx[k];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter feeding one UART TX byte stream. Each grant emits a
// header byte then passes the granted requester through until last, MAX_LEN or stall timeout.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter  int         NUM_REQ  = 4,
    parameter  int         MAX_LEN  = 64,
    parameter  int         TIMEOUT  = 50000,
    parameter  logic [7:0] HDR_BASE = HDR_BASE_DEFAULT,
    localparam int         IDW      = $clog2(NUM_REQ),
    localparam int         BCW      = cnt_width(MAX_LEN + 1),
    localparam int         SCW      = cnt_width(TIMEOUT)
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_tx_arbiter_if.master     bus,
    output logic                  busy,
    output logic [IDW-1:0]        grant_id,
    output logic                  err_timeout,
    output logic                  err_trunc
);

    arb_state_e     state_q;
    logic [IDW-1:0] grant_q;
    logic [IDW-1:0] ptr_q;
    logic [BCW-1:0] byte_cnt_q;
    logic [BCW-1:0] byte_cnt_d;
    logic [SCW-1:0] stall_cnt_q;
    logic [SCW-1:0] stall_cnt_d;
    logic           err_timeout_q;
    logic           err_trunc_q;

    logic           pick_any;
    logic [IDW-1:0] pick_idx;

    logic [7:0]     req_byte [NUM_REQ];
    logic           g_valid;
    logic           g_last;
    logic           xfer;

    uart_tx_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .valid_i     (bus.req_valid),
        .ptr_i       (ptr_q),
        .any_valid_o (pick_any),
        .idx_o       (pick_idx)
    );

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_byte
        assign req_byte[gi] = bus.req_data[8*gi +: 8];
    end

    assign g_valid = bus.req_valid[grant_q];
    assign g_last  = bus.req_last[grant_q];
    assign xfer    = (state_q == ST_DATA) && g_valid && bus.out_ready;

    assign byte_cnt_d  = (byte_cnt_q == BCW'(MAX_LEN))    ? byte_cnt_q  : byte_cnt_q + 1'b1;
    assign stall_cnt_d = (stall_cnt_q == SCW'(TIMEOUT-1)) ? stall_cnt_q : stall_cnt_q + 1'b1;

    // Payload bytes pass straight through so the granted source sees FIFO back-pressure directly.
    always_comb begin
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        bus.req_ready = '0;
        case (state_q)
            ST_HDR: begin
                bus.out_valid = 1'b1;
                bus.out_data  = HDR_BASE | 8'(grant_q);
            end
            ST_DATA: begin
                bus.out_valid          = g_valid;
                bus.out_data           = req_byte[grant_q];
                bus.req_ready[grant_q] = bus.out_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            ptr_q         <= IDW'(NUM_REQ - 1);
            byte_cnt_q    <= '0;
            stall_cnt_q   <= '0;
            err_timeout_q <= 1'b0;
            err_trunc_q   <= 1'b0;
        end else begin
            err_timeout_q <= 1'b0;
            err_trunc_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant_q <= pick_idx;
                        state_q <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (bus.out_ready) begin
                        state_q     <= ST_DATA;
                        byte_cnt_q  <= '0;
                        stall_cnt_q <= '0;
                    end
                end
                ST_DATA: begin
                    if (xfer) begin
                        byte_cnt_q  <= byte_cnt_d;
                        stall_cnt_q <= '0;
                        if (g_last) begin
                            state_q <= ST_IDLE;
                            ptr_q   <= grant_q;
                        end else if (byte_cnt_q == BCW'(MAX_LEN - 1)) begin
                            state_q     <= ST_IDLE;
                            ptr_q       <= grant_q;
                            err_trunc_q <= 1'b1;
                        end
                    end else if (!g_valid) begin
                        // Only an absent source counts as a stall; FIFO back-pressure does not.
                        if (stall_cnt_q == SCW'(TIMEOUT - 1)) begin
                            state_q       <= ST_IDLE;
                            ptr_q         <= grant_q;
                            err_timeout_q <= 1'b1;
                        end else begin
                            stall_cnt_q <= stall_cnt_d;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign grant_id    = grant_q;
    assign err_timeout = err_timeout_q;
    assign err_trunc   = err_trunc_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-driven producers, a packet-level reference model
// of grants, headers, payload, truncation and stall timeout, plus directed scenarios.
module tb_uart_tx_arbiter;

    localparam int         NR   = 4;
    localparam int         MAXL = 4;
    localparam int         TMO  = 16;
    localparam logic [7:0] HB   = 8'hA0;

    typedef struct {
        logic [7:0] data;
        bit         last;
        int         gap;
    } item_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       busy;
    logic [1:0] grant_id;
    logic       err_timeout;
    logic       err_trunc;

    uart_tx_arbiter_if #(.NUM_REQ(NR)) bus_if ();

    uart_tx_arbiter #(
        .NUM_REQ  (NR),
        .MAX_LEN  (MAXL),
        .TIMEOUT  (TMO),
        .HDR_BASE (HB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus_if),
        .busy        (busy),
        .grant_id    (grant_id),
        .err_timeout (err_timeout),
        .err_trunc   (err_trunc)
    );

    always #5 clk = ~clk;

    item_t      src_q [NR][$];
    logic [7:0] out_log [$];
    logic [NR-1:0] acc = '0;
    int  gap_cnt [NR];
    bit  loaded [NR];
    int  rdy_mode = 0;
    int  n_checks = 0;
    int  n_pass   = 0;
    int  eto_seen = 0;
    int  etr_seen = 0;

    // Reference model: phase 0 = between packets, 1 = header pending, 2 = payload.
    int ph = 0, m_gid = 0, m_ptr = NR - 1, m_cnt = 0, m_stall = 0;
    bit m_eto = 0, m_etr = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    endtask

    function automatic int rr_next(input logic [NR-1:0] v, input int ptr);
        for (int k = 1; k <= NR; k++) begin
            if (v[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return ptr;
    endfunction

    task automatic model_reset();
        ph = 0; m_gid = 0; m_ptr = NR - 1; m_cnt = 0; m_stall = 0; m_eto = 0; m_etr = 0;
    endtask

    task automatic close_pkt();
        ph = 0;
        m_ptr = m_gid;
    endtask

    task automatic monitor_cycle();
        logic [NR-1:0] v;
        logic [NR-1:0] er;
        bit            xfer;
        v    = bus_if.req_valid;
        acc  = bus_if.req_valid & bus_if.req_ready;
        xfer = 1'b0;
        if (bus_if.out_valid && bus_if.out_ready) out_log.push_back(bus_if.out_data);
        if (err_timeout) eto_seen++;
        if (err_trunc)   etr_seen++;
        chk("grant_id", grant_id, m_gid);
        chk("err_timeout", err_timeout, m_eto);
        chk("err_trunc", err_trunc, m_etr);
        chk("busy", busy, (ph != 0));
        case (ph)
            0: begin
                chk("idle_out_valid", bus_if.out_valid, 0);
                chk("idle_out_data", bus_if.out_data, 0);
                chk("idle_req_ready", bus_if.req_ready, 0);
            end
            1: begin
                chk("hdr_out_valid", bus_if.out_valid, 1);
                chk("hdr_out_data", bus_if.out_data, HB | m_gid[7:0]);
                chk("hdr_req_ready", bus_if.req_ready, 0);
            end
            default: begin
                er = '0;
                if (bus_if.out_ready) er[m_gid] = 1'b1;
                chk("data_req_ready", bus_if.req_ready, er);
                chk("data_out_valid", bus_if.out_valid, v[m_gid]);
                xfer = v[m_gid] && bus_if.out_ready;
                if (xfer) begin
                    if (src_q[m_gid].size() == 0) chk("data_src_empty", 1, 0);
                    else chk("data_byte", bus_if.out_data, src_q[m_gid][0].data);
                end
            end
        endcase
        m_eto = 0;
        m_etr = 0;
        if (rst) begin
            model_reset();
        end else if (ph == 0) begin
            if (|v) begin
                m_gid = rr_next(v, m_ptr);
                ph = 1;
            end
        end else if (ph == 1) begin
            if (bus_if.out_ready) begin
                ph = 2; m_cnt = 0; m_stall = 0;
            end
        end else if (xfer) begin
            m_cnt++;
            m_stall = 0;
            if (src_q[m_gid].size() > 0 && src_q[m_gid][0].last) close_pkt();
            else if (m_cnt == MAXL) begin close_pkt(); m_etr = 1; end
        end else if (!v[m_gid]) begin
            m_stall++;
            if (m_stall == TMO) begin close_pkt(); m_eto = 1; end
        end
    endtask

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            monitor_cycle();
        end
    end

    // Producers: hold each byte until accepted; an item's gap is the idle cycles before it shows.
    initial begin
        bus_if.req_valid = '0;
        bus_if.req_data  = '0;
        bus_if.req_last  = '0;
        bus_if.out_ready = 1'b0;
        for (int i = 0; i < NR; i++) begin gap_cnt[i] = 0; loaded[i] = 0; end
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (acc[i]) begin src_q[i].delete(0); loaded[i] = 0; end
                bus_if.req_valid[i]       = 1'b0;
                bus_if.req_last[i]        = 1'b0;
                bus_if.req_data[8*i +: 8] = 8'h00;
                if (src_q[i].size() > 0) begin
                    if (!loaded[i]) begin gap_cnt[i] = src_q[i][0].gap; loaded[i] = 1; end
                    if (gap_cnt[i] > 0) gap_cnt[i]--;
                    else begin
                        bus_if.req_valid[i]       = 1'b1;
                        bus_if.req_data[8*i +: 8] = src_q[i][0].data;
                        bus_if.req_last[i]        = src_q[i][0].last;
                    end
                end
            end
            case (rdy_mode)
                0:       bus_if.out_ready = 1'b1;
                1:       bus_if.out_ready = ~bus_if.out_ready;
                default: bus_if.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic push(input int r, input logic [7:0] d, input bit l, input int g);
        item_t it;
        it.data = d; it.last = l; it.gap = g;
        src_q[r].push_back(it);
    endtask

    task automatic wait_drain(input int budget);
        int  t;
        bit  done;
        t = 0; done = 0;
        while (!done && t < budget) begin
            cyc(1);
            t++;
            done = (ph == 0);
            for (int i = 0; i < NR; i++) if (src_q[i].size() != 0) done = 0;
        end
        chk("drain_done", done, 1);
        cyc(2);
    endtask

    task automatic pulse_rst();
        rst = 1'b1; cyc(1); rst = 1'b0; cyc(1);
    endtask

    logic [7:0] e1 [4] = '{8'hA0, 8'h11, 8'h22, 8'h33};
    logic [7:0] e3 [5] = '{8'hA0, 8'h41, 8'h42, 8'h43, 8'h44};
    logic [7:0] e4 [6] = '{8'hA2, 8'h51, 8'hA3, 8'h61, 8'hA2, 8'h52};
    logic [7:0] e5 [8] = '{8'hA1, 8'h71, 8'h72, 8'h73, 8'h74, 8'hA1, 8'h75, 8'h76};
    logic [7:0] e6 [8] = '{8'hA3, 8'h81, 8'h82, 8'h83, 8'hA0, 8'h91, 8'hA3, 8'h84};

    initial begin
        int base_eto, base_etr, t, r, len;
        cyc(3);
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_out_valid", bus_if.out_valid, 0);

        // Single 3-byte packet from requester 0.
        out_log.delete();
        push(0, 8'h11, 0, 0); push(0, 8'h22, 0, 0); push(0, 8'h33, 1, 0);
        wait_drain(200);
        chk("t1_len", out_log.size(), 4);
        for (int k = 0; k < 4; k++) chk("t1_log", out_log[k], e1[k]);

        // All four requesters, two 1-byte packets each: strict rotation from 0.
        pulse_rst();
        out_log.delete();
        for (int j = 0; j < 2; j++)
            for (int i = 0; i < NR; i++) push(i, 8'(16 * i + j), 1, 0);
        wait_drain(400);
        chk("t2_len", out_log.size(), 16);
        for (int k = 0; k < 8; k++) begin
            chk("t2_hdr", out_log[2*k], HB | 8'(k % NR));
            chk("t2_byte", out_log[2*k+1], 8'(16 * (k % NR) + k / NR));
        end

        // Toggling FIFO ready through a full-length packet.
        rdy_mode = 1;
        out_log.delete();
        base_eto = eto_seen;
        for (int b = 0; b < 4; b++) push(0, 8'(8'h41 + b), (b == 3), 0);
        wait_drain(200);
        rdy_mode = 0;
        chk("t3_len", out_log.size(), 5);
        for (int k = 0; k < 5; k++) chk("t3_log", out_log[k], e3[k]);
        chk("t3_no_timeout", eto_seen - base_eto, 0);

        // Requester 2 stalls mid-packet; requester 3 waits and is served next.
        out_log.delete();
        base_eto = eto_seen;
        push(2, 8'h51, 0, 0); push(2, 8'h52, 1, 20);
        push(3, 8'h61, 1, 5);
        wait_drain(400);
        chk("t4_timeouts", eto_seen - base_eto, 1);
        chk("t4_len", out_log.size(), 6);
        for (int k = 0; k < 6; k++) chk("t4_log", out_log[k], e4[k]);

        // 6-byte packet cut at MAX_LEN, remainder re-headed.
        out_log.delete();
        base_etr = etr_seen;
        for (int b = 0; b < 6; b++) push(1, 8'(8'h71 + b), (b == 5), 0);
        wait_drain(400);
        chk("t5_truncs", etr_seen - base_etr, 1);
        chk("t5_len", out_log.size(), 8);
        for (int k = 0; k < 8; k++) chk("t5_log", out_log[k], e5[k]);

        // Reset in the middle of a payload.
        out_log.delete();
        for (int b = 0; b < 4; b++) push(3, 8'(8'h81 + b), (b == 3), 0);
        t = 0;
        while (!(ph == 2 && m_cnt == 2) && t < 100) begin cyc(1); t++; end
        chk("t6_reached_mid", (ph == 2 && m_cnt == 2), 1);
        push(0, 8'h91, 1, 0);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("t6_busy_after_rst", busy, 0);
        chk("t6_ready_after_rst", bus_if.req_ready, 0);
        wait_drain(400);
        chk("t6_len", out_log.size(), 8);
        for (int k = 0; k < 8; k++) chk("t6_log", out_log[k], e6[k]);

        // Randomized batches against the model.
        for (int batch = 0; batch < 10; batch++) begin
            rdy_mode = $urandom_range(0, 2);
            for (int p = 0; p < 6; p++) begin
                r   = $urandom_range(0, NR - 1);
                len = $urandom_range(1, 6);
                for (int b = 0; b < len; b++)
                    push(r, 8'($urandom), (b == len - 1),
                         ($urandom_range(0, 9) == 0) ? 18 : $urandom_range(0, 2));
            end
            wait_drain(3000);
        end

        cyc(5);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
